// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 bus types, timer register map and timer helpers
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam addr_t ADDR_DIV  = 16'hFF04;
    localparam addr_t ADDR_TIMA = 16'hFF05;
    localparam addr_t ADDR_TMA  = 16'hFF06;
    localparam addr_t ADDR_TAC  = 16'hFF07;

    // Cycles TIMA sits at 0x00 after a wrap before the TMA reload cycle
    localparam logic [1:0] OVF_CYCLES = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } timer_state_t;

    function automatic logic [3:0] tac_tap(input logic [1:0] sel);
        case (sel)
            2'b00:   return 4'd9;
            2'b01:   return 4'd3;
            2'b10:   return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/sm83_timer.sv
// rtl/sm83_timer.sv - DIV/TIMA/TMA/TAC timer responder with overflow reload and irq pulse
module sm83_timer
    import sm83_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  addr_t addr,
    input  data_t w_data,
    input  logic  w_wen,
    output data_t r_data,
    output logic  hit,
    output logic  irq_timer
);

    logic [15:0]  r_sys_cnt;
    data_t        r_tima;
    data_t        r_tma;
    logic [2:0]   r_tac;
    timer_state_t r_state;
    logic [1:0]   r_ovf_cnt;
    logic         r_tick_q;
    logic         r_irq;

    logic w_wr_div;
    logic w_wr_tima;
    logic w_wr_tma;
    logic w_wr_tac;
    logic w_tick;
    logic w_fall;

    assign hit       = (addr[15:2] == ADDR_DIV[15:2]);
    assign w_wr_div  = w_wen & hit & (addr[1:0] == ADDR_DIV[1:0]);
    assign w_wr_tima = w_wen & hit & (addr[1:0] == ADDR_TIMA[1:0]);
    assign w_wr_tma  = w_wen & hit & (addr[1:0] == ADDR_TMA[1:0]);
    assign w_wr_tac  = w_wen & hit & (addr[1:0] == ADDR_TAC[1:0]);

    // Any 1->0 of the gated tap counts, including ones caused by DIV/TAC writes
    assign w_tick    = r_tac[2] & r_sys_cnt[tac_tap(r_tac[1:0])];
    assign w_fall    = r_tick_q & ~w_tick;
    assign irq_timer = r_irq;

    always_comb begin
        r_data = 8'h00;
        if (hit) begin
            case (addr[1:0])
                2'b00:   r_data = r_sys_cnt[15:8];
                2'b01:   r_data = r_tima;
                2'b10:   r_data = r_tma;
                default: r_data = {5'b11111, r_tac};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sys_cnt <= 16'h0000;
            r_tima    <= 8'h00;
            r_tma     <= 8'h00;
            r_tac     <= 3'b000;
            r_state   <= RUN;
            r_ovf_cnt <= 2'd0;
            r_tick_q  <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_sys_cnt <= w_wr_div ? 16'h0000 : r_sys_cnt + 16'd1;
            r_tick_q  <= w_tick;
            r_irq     <= 1'b0;
            if (w_wr_tma) r_tma <= w_data;
            if (w_wr_tac) r_tac <= w_data[2:0];

            case (r_state)
                RUN: begin
                    if (w_wr_tima) begin
                        r_tima <= w_data;
                    end else if (w_fall) begin
                        if (r_tima == 8'hFF) begin
                            r_tima    <= 8'h00;
                            r_ovf_cnt <= OVF_CYCLES;
                            r_state   <= OVF;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                OVF: begin
                    if (w_wr_tima) begin
                        r_tima  <= w_data;
                        r_state <= RUN;
                    end else begin
                        r_ovf_cnt <= r_ovf_cnt - 2'd1;
                        if (r_ovf_cnt == 2'd1) r_state <= RELOAD;
                    end
                end
                RELOAD: begin
                    // A TMA write landing on the reload cycle feeds TIMA directly
                    r_tima  <= w_wr_tma ? w_data : r_tma;
                    r_irq   <= 1'b1;
                    r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_timer.sv
// tb/tb_sm83_timer.sv - self-checking bench for sm83_timer with a behavioural reference model
module tb_sm83_timer;
    import sm83_pkg::*;

    logic  clk;
    logic  rst;
    addr_t addr;
    data_t w_data;
    logic  w_wen;
    data_t r_data;
    logic  hit;
    logic  irq_timer;

    int n_checks = 0;
    int n_fail   = 0;

    sm83_timer dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .w_data    (w_data),
        .w_wen     (w_wen),
        .r_data    (r_data),
        .hit       (hit),
        .irq_timer (irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = counting, N>1 = cycles left at 0x00, 1 = reload cycle
    int m_cnt, m_tima, m_tma, m_tac, m_phase;
    bit m_prev, m_irq;

    function automatic bit m_tick();
        int taps[4] = '{9, 3, 5, 7};
        return (((m_tac >> 2) & 1) == 1) && (((m_cnt >> taps[m_tac & 3]) & 1) == 1);
    endfunction

    function automatic int m_read(input logic [15:0] a);
        case (a)
            16'hFF04: return (m_cnt >> 8) & 255;
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return 248 | m_tac;
            default:  return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input logic [15:0] a, input logic [7:0] d, input bit we);
        bit tk, fall, wdiv, wtima, wtma, wtac;
        int n_tima;
        if (r) begin
            m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_phase = 0;
            m_prev = 0; m_irq = 0;
            return;
        end
        tk    = m_tick();
        fall  = m_prev && !tk;
        wdiv  = we && (a == 16'hFF04);
        wtima = we && (a == 16'hFF05);
        wtma  = we && (a == 16'hFF06);
        wtac  = we && (a == 16'hFF07);
        n_tima = m_tima;
        m_irq  = 0;
        if (m_phase == 0) begin
            if (wtima) n_tima = d;
            else if (fall) begin
                if (m_tima == 255) begin
                    n_tima  = 0;
                    m_phase = 4;
                end else n_tima = m_tima + 1;
            end
        end else if (m_phase == 1) begin
            n_tima  = wtma ? int'(d) : m_tma;
            m_irq   = 1;
            m_phase = 0;
        end else begin
            if (wtima) begin
                n_tima  = d;
                m_phase = 0;
            end else m_phase = m_phase - 1;
        end
        m_prev = tk;
        m_cnt  = wdiv ? 0 : ((m_cnt + 1) & 16'hFFFF);
        if (wtma) m_tma = d;
        if (wtac) m_tac = d & 7;
        m_tima = n_tima;
    endtask

    task automatic tick(input logic [15:0] a, input logic [7:0] d, input logic we);
        addr   = a;
        w_data = d;
        w_wen  = we;
        @(posedge clk);
        model_step(rst, a, d, we);
        #1;
        w_wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        addr = a;
        #1;
        v = r_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(16'h0000, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic setup_ovf(output bit ok);
        logic [7:0] v;
        ok = 0;
        do_reset();
        tick(16'hFF06, 8'h80, 1'b1);
        tick(16'hFF05, 8'hFF, 1'b1);
        tick(16'hFF07, 8'h05, 1'b1);
        for (int i = 0; i < 64; i++) begin
            tick(16'h0000, 8'h00, 1'b0);
            rd(16'hFF05, v);
            if (v == 8'h00) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf_wrap_timeout: TIMA never wrapped, last %h required 00", v);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        rd(16'hFF07, v);
        n_checks++; if (v !== 8'hF8) begin n_fail++; $display("FAIL reset_tac: got %h required f8", v); end
        rd(16'hFF05, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_tima: got %h required 00", v); end
        rd(16'hFF04, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_div: got %h required 00", v); end
        n_checks++; if (irq_timer !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", irq_timer); end
        rd(16'hFF08, v);
        n_checks++; if (hit !== 1'b0 || v !== 8'h00) begin n_fail++; $display("FAIL nohit_ff08: hit %b data %h required 0 00", hit, v); end
    endtask

    task automatic test_div();
        logic [7:0] v;
        do_reset();
        repeat (256) tick(16'h0000, 8'h00, 1'b0);
        rd(16'hFF04, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL div_count: got %h required 01", v); end
        tick(16'hFF04, 8'hAB, 1'b1);
        rd(16'hFF04, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL div_clear: got %h required 00", v); end
    endtask

    task automatic test_tima_count();
        logic [7:0] v;
        do_reset();
        tick(16'hFF07, 8'h05, 1'b1);
        repeat (160) tick(16'h0000, 8'h00, 1'b0);
        rd(16'hFF05, v);
        n_checks++; if (v !== 8'h0A) begin n_fail++; $display("FAIL tima_count: got %h required 0a", v); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        bit ok;
        setup_ovf(ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                tick(16'h0000, 8'h00, 1'b0);
                rd(16'hFF05, v);
                n_checks++;
                if (v !== 8'h00 || irq_timer !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_hold_%0d: tima %h irq %b required 00 0", i, v, irq_timer);
                end
            end
            tick(16'h0000, 8'h00, 1'b0);
            rd(16'hFF05, v);
            n_checks++;
            if (v !== 8'h80 || irq_timer !== 1'b1) begin
                n_fail++; $display("FAIL ovf_reload: tima %h irq %b required 80 1", v, irq_timer);
            end
            tick(16'h0000, 8'h00, 1'b0);
            rd(16'hFF05, v);
            n_checks++;
            if (v !== 8'h80 || irq_timer !== 1'b0) begin
                n_fail++; $display("FAIL ovf_irq_len: tima %h irq %b required 80 0", v, irq_timer);
            end
        end
    endtask

    task automatic test_ovf_write();
        logic [7:0] v;
        bit ok;
        int irqs = 0;
        setup_ovf(ok);
        if (ok) begin
            tick(16'hFF05, 8'h42, 1'b1);
            if (irq_timer) irqs++;
            for (int i = 0; i < 8; i++) begin
                tick(16'h0000, 8'h00, 1'b0);
                if (irq_timer) irqs++;
            end
            rd(16'hFF05, v);
            n_checks++; if (v !== 8'h42) begin n_fail++; $display("FAIL ovf_cancel_tima: got %h required 42", v); end
            n_checks++; if (irqs != 0) begin n_fail++; $display("FAIL ovf_cancel_irq: got %0d pulses required 0", irqs); end
        end
    endtask

    task automatic test_glitch(input bit via_tac);
        logic [7:0] v, t0;
        do_reset();
        tick(16'hFF07, 8'h05, 1'b1);
        for (int i = 0; i < 32; i++) begin
            if (((m_cnt >> 3) & 1) == 1) break;
            tick(16'h0000, 8'h00, 1'b0);
        end
        rd(16'hFF05, t0);
        if (via_tac) tick(16'hFF07, 8'h01, 1'b1);
        else         tick(16'hFF04, 8'h00, 1'b1);
        tick(16'h0000, 8'h00, 1'b0);
        rd(16'hFF05, v);
        n_checks++;
        if (v !== t0 + 8'd1) begin
            n_fail++; $display("FAIL glitch_%s: got %h required %h", via_tac ? "tac" : "div", v, t0 + 8'd1);
        end
    endtask

    task automatic test_reset_mid_ovf();
        logic [7:0] v;
        bit ok;
        int irqs = 0;
        setup_ovf(ok);
        if (ok) begin
            tick(16'h0000, 8'h00, 1'b0);
            do_reset();
            if (irq_timer) irqs++;
            rd(16'hFF05, v);
            n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_ovf_tima: got %h required 00", v); end
            rd(16'hFF06, v);
            n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_ovf_tma: got %h required 00", v); end
            rd(16'hFF07, v);
            n_checks++; if (v !== 8'hF8) begin n_fail++; $display("FAIL rst_ovf_tac: got %h required f8", v); end
            for (int i = 0; i < 8; i++) begin
                tick(16'h0000, 8'h00, 1'b0);
                if (irq_timer) irqs++;
            end
            n_checks++; if (irqs != 0) begin n_fail++; $display("FAIL rst_ovf_irq: got %0d pulses required 0", irqs); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  v, d;
        logic [15:0] a;
        logic [15:0] others[3] = '{16'hFF03, 16'hFF08, 16'h1234};
        int op;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            case (op)
                6: tick(16'hFF07, {5'b0, 1'($urandom_range(0, 3) != 0), 1'b0, 1'($urandom)}, 1'b1);
                7: tick(16'hFF05, 8'($urandom_range(8'hF0, 8'hFF)), 1'b1);
                8: tick($urandom_range(0, 3) == 0 ? 16'hFF04 : 16'hFF06, d, 1'b1);
                9: tick(others[$urandom_range(0, 2)], d, 1'b1);
                default: tick(16'h0000, d, 1'b0);
            endcase
            n_checks++;
            if (irq_timer !== m_irq) begin
                n_fail++; $display("FAIL rnd_irq c%0d: got %b required %b", c, irq_timer, m_irq);
            end
            for (int r = 0; r < 4; r++) begin
                a = 16'hFF04 + 16'(r);
                rd(a, v);
                n_checks++;
                if (v !== 8'(m_read(a)) || hit !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_read c%0d %h: got %h hit %b required %h 1", c, a, v, hit, 8'(m_read(a)));
                end
            end
            a = others[c % 3];
            rd(a, v);
            n_checks++;
            if (v !== 8'h00 || hit !== 1'b0) begin
                n_fail++; $display("FAIL rnd_nohit c%0d %h: got %h hit %b required 00 0", c, a, v, hit);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        addr   = 16'h0000;
        w_data = 8'h00;
        w_wen  = 1'b0;
        test_reset();
        test_div();
        test_tima_count();
        test_overflow();
        test_ovf_write();
        test_glitch(1'b0);
        test_glitch(1'b1);
        test_reset_mid_ovf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm83_timer.md
# sm83_timer

Memory-mapped timer/divider responder for the SM83 system bus, implementing DIV (0xFF04), TIMA (0xFF05), TMA (0xFF06) and TAC (0xFF07). It sits beside ROM0/WRAM0 on the shared CPU address bus and answers reads and writes in its four-byte window. It raises a one-cycle timer interrupt request on TIMA overflow. One clk equals one T-cycle (4.194304 MHz nominal).

## Interface
- No parameters; register addresses come from the shared package.
- clk  in  1  system clock, one T-cycle per edge
- rst  in  1  synchronous, active-high reset
- addr  in  addr_t  CPU bus address, shared for read and write
- w_data  in  data_t  CPU write data
- w_wen  in  1  CPU write strobe; qualified internally by address hit
- r_data  out  data_t  read data; 0x00 when `hit` is low
- hit  out  1  combinational; high when addr is in 0xFF04–0xFF07; the top uses it for the read mux
- irq_timer  out  1  one-clk pulse on TIMA reload after overflow

## Operation
- sys_cnt: 16-bit free-running counter, +1 every clk, wraps at 0xFFFF→0x0000. DIV reads sys_cnt[15:8].
- Any write to DIV clears sys_cnt to 0x0000; the written data is ignored.
- TAC holds 3 bits. Bit 2 is enable. Bits 1:0 select the tap: 00→sys_cnt[9], 01→[3], 10→[5], 11→[7]. TAC reads {5'b11111, tac}.
- tick_sig = tac[2] & sys_cnt[tap]. TIMA increments on every 1→0 transition of tick_sig between consecutive cycles, whatever the cause. Causes include normal counting, a DIV write, a TAC write clearing the enable, and a TAC write changing the tap.
- Overflow state machine, timer_state_t:
  - RUN: increment from 0xFF sets TIMA=0x00, ovf_cnt=3, and moves to OVF.
  - OVF: TIMA reads 0x00 and ovf_cnt decrements each clk. At ovf_cnt==0 the next state is RELOAD. A CPU write to TIMA in OVF stores the written value, cancels the reload and irq, and returns to RUN.
  - RELOAD, one clk: TIMA←TMA, irq_timer=1, then RUN. A CPU write to TIMA in this cycle is ignored. A TMA write in this cycle stores the new TMA and also loads the new value into TIMA.
- A TIMA write in RUN coinciding with an increment: the write wins.
- TMA is read/write with no side effects.
- Writes to non-hit addresses have no effect. Reads are side-effect free.

## Timing
- Reset values: sys_cnt=0x0000, TIMA=0x00, TMA=0x00, TAC=3'b000, state=RUN, irq_timer=0. Immediately after reset, r_data for TAC reads 0xF8.
- Reads are combinational from the current registers, valid in the same cycle as addr. This matches the zero-wait bus.
- Writes take effect on the clk edge where w_wen & hit are high. The new value is visible on the next cycle.
- Edge detect uses a registered tick_sig_q. An increment lands 1 clk after the falling edge of tick_sig.
- Overflow to irq: the increment cycle (TIMA=0x00), then 3 OVF cycles, then RELOAD with the irq pulse. The irq therefore fires 4 clks after TIMA wraps.
- rst asserted in any state returns to the reset values on the same edge and drops irq_timer.

## Structure
- Add to sm83_pkg:
  - ADDR_DIV/ADDR_TIMA/ADDR_TMA/ADDR_TAC constants
  - timer_state_t enum {RUN, OVF, RELOAD}
  - a tap-select function mapping tac[1:0] to the bit index
- Use a single module with no sub-module. The address decode and tap mux stay inline.
- Top-level integration:
  - the r_data mux gives priority to timer r_data when hit is high
  - irq_timer goes to a future IF register (0xFF0F, bit 2)

## Test plan
- Reset, then count 0x100 clks → DIV reads 0x01. Write DIV=0xAB → next cycle DIV reads 0x00.
- TAC=0x05 (enable, tap bit3) from reset → TIMA increments once per 16 clks. After 160 clks TIMA=0x0A.
- TMA=0x80, TIMA=0xFF, TAC=0x05:
  - on the next tick TIMA reads 0x00 for 4 clks
  - then TIMA=0x80 with irq_timer high for exactly 1 clk
- Same overflow setup, write TIMA=0x42 during OVF → TIMA=0x42, no irq, no reload.
- TAC=0x05, run until sys_cnt[3]=1, then write DIV → TIMA increments by 1 immediately (falling-edge glitch). The same check applies to a TAC write 0x05→0x01 with sys_cnt[3]=1.
- Read 0xFF07 after reset → 0xF8. Read 0xFF08 → hit=0, r_data=0x00. Assert rst mid-OVF → all registers zero, irq_timer never pulses.
